mem_resp_sram: RTL and testbench

- Memory-side responder for the north-bridge memory port. It sits behind mem_ctrl on the m_* bus and is the device that answers m_re/m_we.
- Byte-wide synchronous SRAM model with a configurable, fully pipelined read latency, an out-of-range error flag and access counters.
- Used as on-chip main memory in simulation and FPGA builds; the CPU side is unaware of the latency except through m_rvalid.

---
 rtl/mem_resp_sram_pkg.sv | 14 +
 rtl/mem_resp_sram_if.sv | 27 ++
 rtl/mem_resp_sram_rd_pipe.sv | 45 ++++
 rtl/mem_resp_sram.sv | 120 ++++++++++++
 tb/tb_mem_resp_sram.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_sram_pkg.sv
// Shared constants and the address range check for the north-bridge memory port.
package mem_pkg;

    localparam int MEM_RD_LAT_MAX = 4;
    localparam int M_DATA_L       = 8;
    localparam int MADDR_L        = 32;
    localparam int MEM_AW         = 16;

    // An address is in range when every bit above the implemented ones is zero.
    function automatic logic addr_in_range(input logic [63:0] addr, input int aw);
        return (addr >> aw) == 64'd0;
    endfunction

endpackage

// File: rtl/mem_resp_sram_if.sv
// Memory-port bus between mem_ctrl (master) and the SRAM responder (slave).
interface mem_resp_sram_if #(
    parameter int M_DATA_L = mem_pkg::M_DATA_L,
    parameter int MADDR_L  = mem_pkg::MADDR_L
);
    // No ready/backpressure: m_re and m_we are taken on every rising edge they are
    // high; each accepted read returns exactly one m_rvalid cycle, in order.
    logic [M_DATA_L-1:0] m_wdata;
    logic [MADDR_L-1:0]  m_raddr;
    logic [MADDR_L-1:0]  m_waddr;
    logic                m_re;
    logic                m_we;
    logic [M_DATA_L-1:0] m_rdata;
    logic                m_rvalid;
    logic                m_rerr;
    logic                m_werr;

    modport master (
        output m_wdata, m_raddr, m_waddr, m_re, m_we,
        input  m_rdata, m_rvalid, m_rerr, m_werr
    );

    modport slave (
        input  m_wdata, m_raddr, m_waddr, m_re, m_we,
        output m_rdata, m_rvalid, m_rerr, m_werr
    );
endinterface

// File: rtl/mem_resp_sram_rd_pipe.sv
// Read-return delay line: DEPTH stages of {valid, err, data}; only valid is reset.
module mem_rd_pipe #(
    parameter int DW    = 8,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_err,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic          out_err,
    output logic [DW-1:0] out_data
);
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] err_q, err_d;
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];

    always_comb begin
        valid_d[0] = in_valid;
        err_d[0]   = in_err;
        data_d[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            err_d[i]   = err_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    // err and data are only meaningful alongside valid, so they need no reset.
    always_ff @(posedge clk) begin
        err_q  <= err_d;
        data_q <= data_d;
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_err   = err_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
endmodule

// File: rtl/mem_resp_sram.sv
// Byte-wide synchronous SRAM responder with pipelined read latency, range errors and counters.
module mem_resp_sram #(
    parameter int M_DATA_L = mem_pkg::M_DATA_L,
    parameter int MADDR_L  = mem_pkg::MADDR_L,
    parameter int MEM_AW   = mem_pkg::MEM_AW,
    parameter int RD_LAT   = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_resp_sram_if.slave   bus,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);
    import mem_pkg::*;

    if (RD_LAT < 1 || RD_LAT > MEM_RD_LAT_MAX) begin : g_bad_rd_lat
        $error("mem_resp_sram: RD_LAT=%0d outside 1..%0d", RD_LAT, MEM_RD_LAT_MAX);
    end

    logic [MADDR_L-1:0]  raddr, waddr;
    logic [MEM_AW-1:0]   ridx, widx;
    logic                raddr_ok, waddr_ok, wr_en;
    logic [M_DATA_L-1:0] mem_q [2**MEM_AW];

    logic                s0_valid_q, s0_valid_d;
    logic                s0_err_q, s0_err_d;
    logic [M_DATA_L-1:0] s0_data_q, s0_data_d;
    logic                werr_q, werr_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [M_DATA_L-1:0] hold_q, hold_d;
    logic                out_valid, out_err;
    logic [M_DATA_L-1:0] out_data;

    assign raddr    = bus.m_raddr;
    assign waddr    = bus.m_waddr;
    assign ridx     = raddr[MEM_AW-1:0];
    assign widx     = waddr[MEM_AW-1:0];
    assign raddr_ok = addr_in_range(64'(raddr), MEM_AW);
    assign waddr_ok = addr_in_range(64'(waddr), MEM_AW);
    assign wr_en    = bus.m_we & waddr_ok;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[widx] <= bus.m_wdata;
    end

    // Stage 0 reads the array at launch; a same-edge write to the same word wins.
    always_comb begin
        s0_valid_d = bus.m_re;
        s0_err_d   = bus.m_re & ~raddr_ok;
        s0_data_d  = s0_data_q;
        if (bus.m_re) begin
            if (!raddr_ok)                  s0_data_d = '0;
            else if (wr_en && widx == ridx) s0_data_d = bus.m_wdata;
            else                            s0_data_d = mem_q[ridx];
        end
    end

    always_comb begin
        werr_d   = bus.m_we & ~waddr_ok;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (bus.m_re && rd_cnt_q != {CNT_W{1'b1}}) rd_cnt_d = rd_cnt_q + CNT_W'(1);
        if (wr_en && wr_cnt_q != {CNT_W{1'b1}})    wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_err_q   <= 1'b0;
            s0_data_q  <= '0;
            werr_q     <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            hold_q     <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_err_q   <= s0_err_d;
            s0_data_q  <= s0_data_d;
            werr_q     <= werr_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            hold_q     <= hold_d;
        end
    end

    if (RD_LAT == 1) begin : g_no_pipe
        assign out_valid = s0_valid_q;
        assign out_err   = s0_err_q;
        assign out_data  = s0_data_q;
    end else begin : g_pipe
        mem_rd_pipe #(
            .DW    (M_DATA_L),
            .DEPTH (RD_LAT - 1)
        ) u_rd_pipe (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (s0_valid_q),
            .in_err    (s0_err_q),
            .in_data   (s0_data_q),
            .out_valid (out_valid),
            .out_err   (out_err),
            .out_data  (out_data)
        );
    end

    // m_rdata keeps the last returned beat while nothing is valid.
    always_comb begin
        hold_d = hold_q;
        if (out_valid) hold_d = out_data;
    end

    assign bus.m_rdata  = hold_d;
    assign bus.m_rvalid = out_valid;
    assign bus.m_rerr   = out_valid & out_err;
    assign bus.m_werr   = werr_q;
    assign rd_cnt       = rd_cnt_q;
    assign wr_cnt       = wr_cnt_q;
endmodule

// File: tb/tb_mem_resp_sram.sv
// Bench for mem_resp_sram: three instances (RD_LAT 1/2/4) share one stimulus stream.
module tb_mem_resp_sram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re = 1'b0, we = 1'b0;
    logic [31:0] raddr = '0, waddr = '0;
    logic [7:0]  wdata = '0;

    always #5 clk = ~clk;

    mem_resp_sram_if #(.M_DATA_L(8), .MADDR_L(32)) if_a ();
    mem_resp_sram_if #(.M_DATA_L(8), .MADDR_L(32)) if_b ();
    mem_resp_sram_if #(.M_DATA_L(8), .MADDR_L(32)) if_c ();

    assign if_a.m_re = re;  assign if_a.m_we = we;  assign if_a.m_raddr = raddr;
    assign if_a.m_waddr = waddr;  assign if_a.m_wdata = wdata;
    assign if_b.m_re = re;  assign if_b.m_we = we;  assign if_b.m_raddr = raddr;
    assign if_b.m_waddr = waddr;  assign if_b.m_wdata = wdata;
    assign if_c.m_re = re;  assign if_c.m_we = we;  assign if_c.m_raddr = raddr;
    assign if_c.m_waddr = waddr;  assign if_c.m_wdata = wdata;

    logic [3:0]  rd_cnt_a, wr_cnt_a;
    logic [15:0] rd_cnt_b, wr_cnt_b, rd_cnt_c, wr_cnt_c;

    mem_resp_sram #(.M_DATA_L(8), .MADDR_L(32), .MEM_AW(16), .RD_LAT(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a), .rd_cnt(rd_cnt_a), .wr_cnt(wr_cnt_a));
    mem_resp_sram #(.M_DATA_L(8), .MADDR_L(32), .MEM_AW(16), .RD_LAT(2), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b), .rd_cnt(rd_cnt_b), .wr_cnt(wr_cnt_b));
    mem_resp_sram #(.M_DATA_L(8), .MADDR_L(32), .MEM_AW(16), .RD_LAT(4), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c), .rd_cnt(rd_cnt_c), .wr_cnt(wr_cnt_c));

    // ---------------- reference model ----------------
    typedef struct {
        int         dut;
        int         due;
        logic [7:0] data;
        logic       err;
    } beat_t;

    beat_t      exp_q [$];
    logic [7:0] model_mem [int];
    int         rd_n [3];
    int         wr_n [3];
    logic [7:0] last_data [3];
    logic       werr_exp;
    int         cyc;
    int         tests = 0;
    int         fails = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 4;
    endfunction

    function automatic int cmax_of(input int d);
        return (d == 0) ? 15 : 65535;
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return a[31:16] == 16'h0;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d cyc%0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    task automatic read_outs(input int d, output logic v, output logic [7:0] data,
                             output logic err, output logic werr, output int rdc, output int wrc);
        case (d)
            0: begin v = if_a.m_rvalid; data = if_a.m_rdata; err = if_a.m_rerr; werr = if_a.m_werr;
                     rdc = int'(rd_cnt_a); wrc = int'(wr_cnt_a); end
            1: begin v = if_b.m_rvalid; data = if_b.m_rdata; err = if_b.m_rerr; werr = if_b.m_werr;
                     rdc = int'(rd_cnt_b); wrc = int'(wr_cnt_b); end
            default: begin v = if_c.m_rvalid; data = if_c.m_rdata; err = if_c.m_rerr; werr = if_c.m_werr;
                     rdc = int'(rd_cnt_c); wrc = int'(wr_cnt_c); end
        endcase
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int d = 0; d < 3; d++) begin
            rd_n[d] = 0; wr_n[d] = 0; last_data[d] = 8'h00;
        end
        werr_exp = 1'b0;
    endtask

    // Applies the current inputs to the model as if the next rising edge took them.
    task automatic model_edge();
        logic [7:0] rd_val;
        logic       rd_err;
        rd_err = !in_rng(raddr);
        if (rd_err)                                      rd_val = 8'h00;
        else if (we && in_rng(waddr) && waddr == raddr) rd_val = wdata;
        else if (model_mem.exists(int'(raddr)))         rd_val = model_mem[int'(raddr)];
        else                                             rd_val = 8'h00;
        for (int d = 0; d < 3; d++) begin
            if (re) begin
                exp_q.push_back('{d, cyc + lat_of(d), rd_val, rd_err});
                if (rd_n[d] < cmax_of(d)) rd_n[d]++;
            end
            if (we && in_rng(waddr) && wr_n[d] < cmax_of(d)) wr_n[d]++;
        end
        if (we && in_rng(waddr)) model_mem[int'(waddr)] = wdata;
        werr_exp = we && !in_rng(waddr);
    endtask

    task automatic check_all();
        logic v, err, werr, ev, ee;
        logic [7:0] data, ed;
        int rdc, wrc, idx;
        for (int d = 0; d < 3; d++) begin
            read_outs(d, v, data, err, werr, rdc, wrc);
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].dut == d) begin idx = i; break; end
            end
            ev = 1'b0; ed = last_data[d]; ee = 1'b0;
            if (idx >= 0 && exp_q[idx].due == cyc) begin
                ev = 1'b1; ed = exp_q[idx].data; ee = exp_q[idx].err;
                last_data[d] = ed;
                exp_q.delete(idx);
            end
            chk("rvalid", d, 32'(v), 32'(ev));
            chk("rdata",  d, 32'(data), 32'(ed));
            chk("rerr",   d, 32'(err), 32'(ee));
            chk("werr",   d, 32'(werr), 32'(werr_exp));
            chk("rd_cnt", d, rdc, rd_n[d]);
            chk("wr_cnt", d, wrc, wr_n[d]);
        end
    endtask

    task automatic step(input logic s_re, input logic [31:0] s_ra, input logic s_we,
                        input logic [31:0] s_wa, input logic [7:0] s_wd);
        re = s_re; raddr = s_ra; we = s_we; waddr = s_wa; wdata = s_wd;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
    endtask

    task automatic check_reset_state(input string tag);
        logic v, err, werr;
        logic [7:0] data;
        int rdc, wrc;
        for (int d = 0; d < 3; d++) begin
            read_outs(d, v, data, err, werr, rdc, wrc);
            chk({tag, "_rvalid"}, d, 32'(v), 32'd0);
            chk({tag, "_rdata"},  d, 32'(data), 32'd0);
            chk({tag, "_rerr"},   d, 32'(err), 32'd0);
            chk({tag, "_werr"},   d, 32'(werr), 32'd0);
            chk({tag, "_rd_cnt"}, d, rdc, 0);
            chk({tag, "_wr_cnt"}, d, wrc, 0);
        end
    endtask

    // ---------------- directed table (expectations for the RD_LAT=2 instance) ----------------
    typedef struct {
        logic        re;
        logic [31:0] raddr;
        logic        we;
        logic [31:0] waddr;
        logic [7:0]  wdata;
        logic        e_v;
        logic [7:0]  e_d;
        logic        e_err;
        logic        e_werr;
        int          e_rd;
        int          e_wr;
    } vec_t;

    vec_t vt [16];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic v, err, werr;
        logic [7:0] data;
        int rdc, wrc, seen [3], nvalid, first_k, last_k;
        logic [7:0] got_q [$];

        vt[0]  = '{1'b0, 32'h0,       1'b1, 32'h00,      8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1};
        vt[1]  = '{1'b0, 32'h0,       1'b1, 32'h10,      8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 0, 2};
        vt[2]  = '{1'b1, 32'h10,      1'b0, 32'h0,       8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1, 2};
        vt[3]  = '{1'b0, 32'h0,       1'b0, 32'h0,       8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, 1, 2};
        vt[4]  = '{1'b0, 32'h0,       1'b1, 32'h20,      8'h11, 1'b0, 8'hA5, 1'b0, 1'b0, 1, 3};
        vt[5]  = '{1'b1, 32'h20,      1'b1, 32'h20,      8'h3C, 1'b0, 8'hA5, 1'b0, 1'b0, 2, 4};
        vt[6]  = '{1'b1, 32'h20,      1'b0, 32'h0,       8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 3, 4};
        vt[7]  = '{1'b0, 32'h0,       1'b1, 32'h20,      8'h77, 1'b1, 8'h3C, 1'b0, 1'b0, 3, 5};
        vt[8]  = '{1'b1, 32'h1_0000,  1'b0, 32'h0,       8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 4, 5};
        vt[9]  = '{1'b0, 32'h0,       1'b1, 32'h1_0000,  8'h5A, 1'b1, 8'h00, 1'b1, 1'b1, 4, 5};
        vt[10] = '{1'b0, 32'h0,       1'b0, 32'h0,       8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4, 5};
        vt[11] = '{1'b0, 32'h0,       1'b0, 32'h0,       8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4, 5};
        vt[12] = '{1'b1, 32'h20,      1'b0, 32'h0,       8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5, 5};
        vt[13] = '{1'b1, 32'h00,      1'b0, 32'h0,       8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 6, 5};
        vt[14] = '{1'b0, 32'h0,       1'b0, 32'h0,       8'h00, 1'b1, 8'h99, 1'b0, 1'b0, 6, 5};
        vt[15] = '{1'b0, 32'h0,       1'b0, 32'h0,       8'h00, 1'b0, 8'h99, 1'b0, 1'b0, 6, 5};

        cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(vt[i].re, vt[i].raddr, vt[i].we, vt[i].waddr, vt[i].wdata);
            read_outs(1, v, data, err, werr, rdc, wrc);
            chk("tbl_rvalid", i, 32'(v), 32'(vt[i].e_v));
            chk("tbl_rdata",  i, 32'(data), 32'(vt[i].e_d));
            chk("tbl_rerr",   i, 32'(err), 32'(vt[i].e_err));
            chk("tbl_werr",   i, 32'(werr), 32'(vt[i].e_werr));
            chk("tbl_rd_cnt", i, rdc, vt[i].e_rd);
            chk("tbl_wr_cnt", i, wrc, vt[i].e_wr);
        end

        // Burst: data = address, then eight back-to-back reads.
        for (int a = 0; a < 8; a++) step(1'b0, 32'h0, 1'b1, 32'(a), 8'(a));
        nvalid = 0; first_k = -1; last_k = -1;
        for (int k = 0; k < 12; k++) begin
            if (k < 8) step(1'b1, 32'(k), 1'b0, 32'h0, 8'h00);
            else       idle(1);
            read_outs(1, v, data, err, werr, rdc, wrc);
            if (v) begin
                nvalid++;
                got_q.push_back(data);
                if (first_k < 0) first_k = k;
                last_k = k;
            end
        end
        chk("burst_count", 1, nvalid, 8);
        chk("burst_contig", 1, last_k - first_k + 1, 8);
        for (int i = 0; i < got_q.size(); i++) chk("burst_order", 1, 32'(got_q[i]), i);

        // Latency per instance from a single isolated read.
        idle(5);
        for (int d = 0; d < 3; d++) seen[d] = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 1) step(1'b1, 32'h10, 1'b0, 32'h0, 8'h00);
            else        idle(1);
            for (int d = 0; d < 3; d++) begin
                read_outs(d, v, data, err, werr, rdc, wrc);
                if (seen[d] == 0 && v) seen[d] = k;
            end
        end
        for (int d = 0; d < 3; d++) chk("latency", d, seen[d], lat_of(d));

        // Asynchronous reset with three reads in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h10, 1'b0, 32'h0, 8'h00);
        re = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(6);
        step(1'b1, 32'h10, 1'b0, 32'h0, 8'h00);
        idle(4);

        // Counter saturation on the 4-bit instance.
        for (int i = 0; i < 20; i++) step(1'b1, 32'h10, 1'b0, 32'h0, 8'h00);
        idle(4);
        read_outs(0, v, data, err, werr, rdc, wrc);
        chk("rd_cnt_sat", 0, rdc, 15);

        // Randomised traffic against the model.
        for (int a = 0; a < 32; a++) step(1'b0, 32'h0, 1'b1, 32'(a), 8'($urandom_range(0, 255)));
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, wa;
            ra = ($urandom_range(0, 7) == 0) ? {16'($urandom_range(1, 65535)), 16'($urandom_range(0, 31))}
                                             : 32'($urandom_range(0, 31));
            wa = ($urandom_range(0, 7) == 0) ? {16'($urandom_range(1, 65535)), 16'($urandom_range(0, 31))}
                                             : 32'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, 8'($urandom_range(0, 255)));
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
